// File: rtl/rvfi_shadow_checker.sv
// Cross-instruction RVFI stream checker: shadow register file, PC and order continuity.
// Optional macro RISCV_FORMAL_SHADOW_INTR_EN adds rvfi_intr to waive the PC check on trap-handler entry.
module rvfi_shadow_checker #(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int NREGS = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [64*NRET-1:0]     rvfi_order,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [5*NRET-1:0]      rvfi_rs1_addr,
  input  logic [5*NRET-1:0]      rvfi_rs2_addr,
  input  logic [XLEN*NRET-1:0]   rvfi_rs1_rdata,
  input  logic [XLEN*NRET-1:0]   rvfi_rs2_rdata,
  input  logic [5*NRET-1:0]      rvfi_rd_addr,
  input  logic [XLEN*NRET-1:0]   rvfi_rd_wdata,
  input  logic [XLEN*NRET-1:0]   rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]   rvfi_pc_wdata,
`ifdef RISCV_FORMAL_SHADOW_INTR_EN
  input  logic [NRET-1:0]        rvfi_intr,
`endif
  output logic                   err,
  output logic [2:0]             err_cause,
  output logic [1:0]             err_slot,
  output logic [63:0]            err_order,
  output logic [31:0]            retired_count
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [2:0] CAUSE_RS1   = 3'd1;
  localparam logic [2:0] CAUSE_RS2   = 3'd2;
  localparam logic [2:0] CAUSE_X0WR  = 3'd3;
  localparam logic [2:0] CAUSE_PC    = 3'd4;
  localparam logic [2:0] CAUSE_ORDER = 3'd5;
  localparam logic [2:0] CAUSE_RANGE = 3'd6;

  function automatic logic in_range(input logic [4:0] a);
    return {27'd0, a} < $unsigned(NREGS);
  endfunction

  logic [XLEN-1:0]  shadow_q [NREGS];
  logic [XLEN-1:0]  shadow_d [NREGS];
  logic [NREGS-1:0] known_q, known_d;
  logic [63:0]      exp_order_q, exp_order_d;
  logic [XLEN-1:0]  exp_pc_q, exp_pc_d;
  logic             have_prev_q, have_prev_d;
  logic             err_q, err_d;
  logic [2:0]       err_cause_q, err_cause_d;
  logic [1:0]       err_slot_q, err_slot_d;
  logic [63:0]      err_order_q, err_order_d;
  logic [31:0]      count_q, count_d;

  logic             found;
  logic [2:0]       found_cause;
  logic [1:0]       found_slot;
  logic [63:0]      found_order;
  logic [32:0]      count_sum;
  logic [2:0]       slot_cause;
  logic             slot_intr;
  logic             slot_trap;
  logic [63:0]      slot_order;
  logic [4:0]       rs1_a, rs2_a, rd_a;
  logic [IDXW-1:0]  rs1_i, rs2_i, rd_i;
  logic [XLEN-1:0]  rs1_v, rs2_v, rd_v, pc_r, pc_w;
  logic             rs1_bad, rs2_bad;

  // Slots are walked in ascending order so each sees the state left by the ones before it.
  always_comb begin
    shadow_d    = shadow_q;
    known_d     = known_q;
    exp_order_d = exp_order_q;
    exp_pc_d    = exp_pc_q;
    have_prev_d = have_prev_q;
    err_d       = err_q;
    err_cause_d = err_cause_q;
    err_slot_d  = err_slot_q;
    err_order_d = err_order_q;
    found       = 1'b0;
    found_cause = '0;
    found_slot  = '0;
    found_order = '0;
    count_sum   = {1'b0, count_q};
    slot_cause  = '0;
    slot_intr   = 1'b0;
    slot_trap   = 1'b0;
    slot_order  = '0;
    rs1_a       = '0;
    rs2_a       = '0;
    rd_a        = '0;
    rs1_i       = '0;
    rs2_i       = '0;
    rd_i        = '0;
    rs1_v       = '0;
    rs2_v       = '0;
    rd_v        = '0;
    pc_r        = '0;
    pc_w        = '0;
    rs1_bad     = 1'b0;
    rs2_bad     = 1'b0;

    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid[k]) begin
        rs1_a      = rvfi_rs1_addr[5*k +: 5];
        rs2_a      = rvfi_rs2_addr[5*k +: 5];
        rd_a       = rvfi_rd_addr[5*k +: 5];
        rs1_i      = rs1_a[IDXW-1:0];
        rs2_i      = rs2_a[IDXW-1:0];
        rd_i       = rd_a[IDXW-1:0];
        rs1_v      = rvfi_rs1_rdata[XLEN*k +: XLEN];
        rs2_v      = rvfi_rs2_rdata[XLEN*k +: XLEN];
        rd_v       = rvfi_rd_wdata[XLEN*k +: XLEN];
        pc_r       = rvfi_pc_rdata[XLEN*k +: XLEN];
        pc_w       = rvfi_pc_wdata[XLEN*k +: XLEN];
        slot_order = rvfi_order[64*k +: 64];
        slot_trap  = rvfi_trap[k];
`ifdef RISCV_FORMAL_SHADOW_INTR_EN
        slot_intr  = rvfi_intr[k];
`else
        slot_intr  = 1'b0;
`endif
        rs1_bad = (rs1_a == 5'd0) ? (rs1_v != '0)
                                  : (known_d[rs1_i] && (rs1_v != shadow_d[rs1_i]));
        rs2_bad = (rs2_a == 5'd0) ? (rs2_v != '0)
                                  : (known_d[rs2_i] && (rs2_v != shadow_d[rs2_i]));

        slot_cause = '0;
        if (!in_range(rs1_a) || !in_range(rs2_a) || !in_range(rd_a))
          slot_cause = CAUSE_RANGE;
        else if (have_prev_d && (slot_order != exp_order_d))
          slot_cause = CAUSE_ORDER;
        else if (have_prev_d && !slot_intr && (pc_r != exp_pc_d))
          slot_cause = CAUSE_PC;
        else if (!slot_trap && rs1_bad)
          slot_cause = CAUSE_RS1;
        else if (!slot_trap && rs2_bad)
          slot_cause = CAUSE_RS2;
        else if (!slot_trap && (rd_a == 5'd0) && (rd_v != '0))
          slot_cause = CAUSE_X0WR;

        if ((slot_cause != '0) && !found) begin
          found       = 1'b1;
          found_cause = slot_cause;
          found_slot  = 2'(k);
          found_order = slot_order;
        end

        exp_order_d = slot_order + 64'd1;
        exp_pc_d    = pc_w;
        have_prev_d = 1'b1;
        if (!slot_trap && (rd_a != 5'd0) && in_range(rd_a)) begin
          shadow_d[rd_i] = rd_v;
          known_d[rd_i]  = 1'b1;
        end
        count_sum = count_sum + 33'd1;
      end
    end

    count_d = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];

    if (found && !err_q) begin
      err_d       = 1'b1;
      err_cause_d = found_cause;
      err_slot_d  = found_slot;
      err_order_d = found_order;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      known_q     <= '0;
      exp_order_q <= '0;
      exp_pc_q    <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      err_cause_q <= '0;
      err_slot_q  <= '0;
      err_order_q <= '0;
      count_q     <= '0;
    end else begin
      known_q     <= known_d;
      exp_order_q <= exp_order_d;
      exp_pc_q    <= exp_pc_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
      err_slot_q  <= err_slot_d;
      err_order_q <= err_order_d;
      count_q     <= count_d;
    end
  end

  // Data needs no reset: entries are only trusted once their known bit is set.
  always_ff @(posedge clock) begin
    shadow_q <= shadow_d;
  end

  assign err           = err_q;
  assign err_cause     = err_cause_q;
  assign err_slot      = err_slot_q;
  assign err_order     = err_order_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_rvfi_shadow_checker.sv
// Directed bench for rvfi_shadow_checker (NRET=2, NREGS=16) with a queue of expected error state.
module tb_rvfi_shadow_checker;

  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int NREGS = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [NRET-1:0]      rvfi_trap;
  logic [5*NRET-1:0]    rvfi_rs1_addr;
  logic [5*NRET-1:0]    rvfi_rs2_addr;
  logic [XLEN*NRET-1:0] rvfi_rs1_rdata;
  logic [XLEN*NRET-1:0] rvfi_rs2_rdata;
  logic [5*NRET-1:0]    rvfi_rd_addr;
  logic [XLEN*NRET-1:0] rvfi_rd_wdata;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata;
  logic [XLEN*NRET-1:0] rvfi_pc_wdata;
  logic [NRET-1:0]      rvfi_intr;
  logic                 err;
  logic [2:0]           err_cause;
  logic [1:0]           err_slot;
  logic [63:0]          err_order;
  logic [31:0]          retired_count;

  rvfi_shadow_checker #(.XLEN(XLEN), .NRET(NRET), .NREGS(NREGS)) dut (
    .clock          (clock),
    .reset          (reset),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_trap      (rvfi_trap),
    .rvfi_rs1_addr  (rvfi_rs1_addr),
    .rvfi_rs2_addr  (rvfi_rs2_addr),
    .rvfi_rs1_rdata (rvfi_rs1_rdata),
    .rvfi_rs2_rdata (rvfi_rs2_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_pc_wdata  (rvfi_pc_wdata),
`ifdef RISCV_FORMAL_SHADOW_INTR_EN
    .rvfi_intr      (rvfi_intr),
`endif
    .err            (err),
    .err_cause      (err_cause),
    .err_slot       (err_slot),
    .err_order      (err_order),
    .retired_count  (retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic        trap;
    logic        intr;
    logic [63:0] order;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1d, rs2d, rdw, pc, pcn;
  } slot_t;

  typedef struct {
    logic        err;
    logic [2:0]  cause;
    logic [1:0]  slot;
    logic [63:0] order;
    logic [31:0] count;
  } exp_t;

  slot_t       slots [NRET];
  exp_t        sb [$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_count = '0;

  task automatic clear_slots();
    for (int k = 0; k < NRET; k++) begin
      slots[k].valid = 1'b0;
      slots[k].trap  = 1'b0;
      slots[k].intr  = 1'b0;
      slots[k].order = '0;
      slots[k].rs1   = '0;
      slots[k].rs2   = '0;
      slots[k].rd    = '0;
      slots[k].rs1d  = '0;
      slots[k].rs2d  = '0;
      slots[k].rdw   = '0;
      slots[k].pc    = '0;
      slots[k].pcn   = '0;
    end
  endtask

  task automatic set_slot(input int k, input logic [63:0] order, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [31:0] rdw,
                          input logic [4:0] rs1, input logic [31:0] rs1d,
                          input logic [4:0] rs2, input logic [31:0] rs2d);
    slots[k].valid = 1'b1;
    slots[k].order = order;
    slots[k].pc    = pc;
    slots[k].pcn   = pc + 32'd4;
    slots[k].rd    = rd;
    slots[k].rdw   = rdw;
    slots[k].rs1   = rs1;
    slots[k].rs1d  = rs1d;
    slots[k].rs2   = rs2;
    slots[k].rs2d  = rs2d;
  endtask

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    compare("err",           64'(err),           64'(e.err));
    compare("err_cause",     64'(err_cause),     64'(e.cause));
    compare("err_slot",      64'(err_slot),      64'(e.slot));
    compare("err_order",     err_order,          e.order);
    compare("retired_count", 64'(retired_count), 64'(e.count));
  endtask

  // One clock of stimulus; expected state after the capturing edge is queued before the edge.
  task automatic apply_stimulus(input logic rst, input logic e_err, input logic [2:0] e_cause,
                                input logic [1:0] e_slot, input logic [63:0] e_order);
    exp_t e;
    reset = rst;
    for (int k = 0; k < NRET; k++) begin
      rvfi_valid[k]                   = slots[k].valid;
      rvfi_trap[k]                    = slots[k].trap;
      rvfi_intr[k]                    = slots[k].intr;
      rvfi_order[64*k +: 64]          = slots[k].order;
      rvfi_rs1_addr[5*k +: 5]         = slots[k].rs1;
      rvfi_rs2_addr[5*k +: 5]         = slots[k].rs2;
      rvfi_rd_addr[5*k +: 5]          = slots[k].rd;
      rvfi_rs1_rdata[XLEN*k +: XLEN]  = slots[k].rs1d;
      rvfi_rs2_rdata[XLEN*k +: XLEN]  = slots[k].rs2d;
      rvfi_rd_wdata[XLEN*k +: XLEN]   = slots[k].rdw;
      rvfi_pc_rdata[XLEN*k +: XLEN]   = slots[k].pc;
      rvfi_pc_wdata[XLEN*k +: XLEN]   = slots[k].pcn;
    end
    if (rst)
      model_count = '0;
    else
      for (int k = 0; k < NRET; k++)
        if (slots[k].valid) model_count = model_count + 32'd1;
    e.err   = e_err;
    e.cause = e_cause;
    e.slot  = e_slot;
    e.order = e_order;
    e.count = model_count;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_output();
    @(negedge clock);
    reset = 1'b0;
    clear_slots();
  endtask

  task automatic do_reset();
    set_slot(0, 64'd99, 32'hDEAD, 5'd3, 32'h1, 5'd0, 32'h5, 5'd0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'd0, 2'd0, 64'd0);
  endtask

  initial begin
    clear_slots();
    reset = 1'b1;
    do_reset();
    do_reset();

    // Write then read back through the shadow file, then a bad read.
    set_slot(0, 64'd0, 32'h100, 5'd5, 32'h1234, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(0, 64'd1, 32'h104, 5'd6, 32'h55, 5'd5, 32'h1234, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(0, 64'd2, 32'h108, 5'd0, 32'h0, 5'd5, 32'h1235, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd1, 2'd0, 64'd2);
    do_reset();

    // Same-cycle forwarding, baseline at arbitrary order after reset, then frozen capture.
    set_slot(0, 64'd10, 32'h200, 5'd7, 32'hA, 5'd0, 32'h0, 5'd0, 32'h0);
    set_slot(1, 64'd11, 32'h204, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'hA);
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(0, 64'd12, 32'h208, 5'd7, 32'hC, 5'd0, 32'h0, 5'd0, 32'h0);
    set_slot(1, 64'd13, 32'h20C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'hB);
    apply_stimulus(1'b0, 1'b1, 3'd2, 2'd1, 64'd13);
    set_slot(0, 64'd20, 32'h210, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd2, 2'd1, 64'd13);
    do_reset();

    // Order gap, then a later PC mismatch must not overwrite the cause.
    set_slot(0, 64'd4, 32'h300, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(0, 64'd6, 32'h304, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd5, 2'd0, 64'd6);
    set_slot(0, 64'd7, 32'h999, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd5, 2'd0, 64'd6);
    do_reset();

    // Out-of-range rd on slot 1 with slot 0 idle.
    set_slot(0, 64'd0, 32'h0, 5'd3, 32'h33, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(1, 64'd1, 32'h4, 5'd20, 32'h1, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd6, 2'd1, 64'd1);
    do_reset();

    // Trap skips source checks and does not write rd; x0 write on slot 1.
    set_slot(0, 64'd0, 32'h40, 5'd9, 32'h99, 5'd0, 32'h77, 5'd0, 32'h0);
    slots[0].trap = 1'b1;
    slots[0].pcn  = 32'h80;
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(0, 64'd1, 32'h80, 5'd0, 32'h0, 5'd9, 32'h1, 5'd0, 32'h0);
    set_slot(1, 64'd2, 32'h84, 5'd0, 32'h5, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd3, 2'd1, 64'd2);
    do_reset();

    // Both slots write x4 in one cycle: the higher slot's value must stick.
    set_slot(0, 64'd0, 32'h0, 5'd4, 32'h1, 5'd0, 32'h0, 5'd0, 32'h0);
    set_slot(1, 64'd1, 32'h4, 5'd4, 32'h2, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(0, 64'd2, 32'h8, 5'd0, 32'h0, 5'd4, 32'h2, 5'd0, 32'h0);
    set_slot(1, 64'd3, 32'hC, 5'd0, 32'h0, 5'd4, 32'h1, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd1, 2'd1, 64'd3);
    do_reset();

    // PC discontinuity, optionally waived for a trap-handler entry.
    set_slot(0, 64'd0, 32'h10, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
`ifdef RISCV_FORMAL_SHADOW_INTR_EN
    set_slot(0, 64'd1, 32'h18, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    slots[0].intr = 1'b1;
    apply_stimulus(1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    set_slot(0, 64'd2, 32'h30, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd4, 2'd0, 64'd2);
`else
    set_slot(0, 64'd1, 32'h18, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd4, 2'd0, 64'd1);
`endif

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
